// File: rtl/trig_pid_outstage.sv
// PID trigger output stage: per-channel edge detect, mask, prescale and pulse
// stretching, with saturating raw/accepted scalers on the data/addr/rd/wr bus.
module trig_pid_outstage #(
  parameter int          NCH       = 6,
  parameter int          PS_W      = 8,
  parameter int          CNT_W     = 24,
  parameter int          STRETCH_W = 4,
  parameter logic [15:0] BASE_ADDR = 16'hA000
) (
  input  logic            clk_100_i,
  input  logic            reset_i,
  input  logic [NCH-1:0]  trig_in,
  input  logic [31:0]     data,
  input  logic [15:0]     addr,
  input  logic            wr,
  input  logic            rd,
  output logic [31:0]     rdata,
  output logic            ack,
  output logic            unknown,
  output logic [NCH-1:0]  trig_out,
  output logic            trig_or
);

  localparam logic [PS_W-1:0]      PS_ONE = PS_W'(1);
  localparam logic [STRETCH_W-1:0] ST_ONE = STRETCH_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

  // Control registers
  logic                 en;
  logic [NCH-1:0]       mask;
  logic [STRETCH_W-1:0] stretch;
  logic [STRETCH_W-1:0] stretch_eff;
  logic [PS_W-1:0]      prescale [NCH];

  // Per-channel datapath state
  logic [NCH-1:0]       s0, s1, rise, elig, fire;
  logic [PS_W-1:0]      pc       [NCH];
  logic [PS_W-1:0]      p_eff    [NCH];
  logic [PS_W-1:0]      pc_eff   [NCH];
  logic [STRETCH_W-1:0] pcnt     [NCH];
  logic [CNT_W-1:0]     raw      [NCH];
  logic [CNT_W-1:0]     acc      [NCH];

  // Bus decode
  logic       hit, wr_en, rd_en, mapped, idx_ok, clear;
  logic       wr_ctrl, wr_mask, wr_stretch;
  logic [5:0] off;
  logic [3:0] idx;
  logic [NCH-1:0] wr_ps;
  logic [31:0] rd_val;
  logic        unused_data;

  assign unused_data = ^data;

  assign hit    = (addr[15:6] == BASE_ADDR[15:6]);
  assign off    = addr[5:0];
  assign idx    = off[3:0];
  assign idx_ok = ({28'd0, idx} < 32'(NCH));
  assign mapped = (off[5:4] == 2'd0) ? (idx <= 4'd2) : idx_ok;

  // A simultaneous wr and rd is treated as a write only.
  assign wr_en = hit & wr;
  assign rd_en = hit & rd & ~wr;

  assign wr_ctrl    = wr_en & (off == 6'h00);
  assign wr_mask    = wr_en & (off == 6'h01);
  assign wr_stretch = wr_en & (off == 6'h02);
  assign clear      = wr_ctrl & data[1];

  assign stretch_eff = (stretch == '0) ? ST_ONE : stretch;
  assign rise        = s0 & ~s1;
  assign trig_or     = |trig_out;

  // NOTE: every variable written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    wr_ps = '0;
    elig  = '0;
    fire  = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_ps[i] = wr_en && (off[5:4] == 2'd1) && (idx == i[3:0]);
      // A prescale write restarts the count and takes effect for this cycle's edge.
      p_eff[i]  = wr_ps[i] ? data[PS_W-1:0] : prescale[i];
      pc_eff[i] = wr_ps[i] ? '0 : pc[i];
      elig[i]   = rise[i] & en & mask[i] & (pcnt[i] == '0);
      fire[i]   = elig[i] & ((p_eff[i] <= PS_ONE) || (pc_eff[i] == p_eff[i] - PS_ONE));
    end
  end

  always_comb begin
    rd_val = 32'hDEADBEEF;
    case (off[5:4])
      2'd0: begin
        if (off[3:0] == 4'd0)      rd_val = {31'd0, en};
        else if (off[3:0] == 4'd1) rd_val = 32'(mask);
        else if (off[3:0] == 4'd2) rd_val = 32'(stretch);
      end
      2'd1: for (int i = 0; i < NCH; i++) if (idx == i[3:0]) rd_val = 32'(prescale[i]);
      2'd2: for (int i = 0; i < NCH; i++) if (idx == i[3:0]) rd_val = 32'(raw[i]);
      default: for (int i = 0; i < NCH; i++) if (idx == i[3:0]) rd_val = 32'(acc[i]);
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_100_i or negedge reset_i) begin
    if (!reset_i) begin
      en      <= 1'b1;
      mask    <= '1;
      stretch <= ST_ONE;
      ack     <= 1'b0;
      unknown <= 1'b0;
      rdata   <= '0;
    end else begin
      if (wr_ctrl)    en      <= data[0];
      if (wr_mask)    mask    <= data[NCH-1:0];
      if (wr_stretch) stretch <= data[STRETCH_W-1:0];
      ack     <= hit & (wr | rd);
      unknown <= hit & (wr | rd) & ~mapped;
      if (rd_en) rdata <= rd_val;
    end
  end

  // NOTE: the per-channel arrays are small register files, not RAM, so they
  // take the asynchronous reset like any other flop.
  always_ff @(posedge clk_100_i or negedge reset_i) begin
    if (!reset_i) begin
      s0       <= '0;
      s1       <= '0;
      trig_out <= '0;
      for (int i = 0; i < NCH; i++) begin
        prescale[i] <= PS_ONE;
        pc[i]       <= '0;
        pcnt[i]     <= '0;
        raw[i]      <= '0;
        acc[i]      <= '0;
      end
    end else begin
      s0 <= trig_in;
      s1 <= s0;
      for (int i = 0; i < NCH; i++) begin
        trig_out[i] <= (pcnt[i] != '0);
        if (wr_ps[i]) prescale[i] <= data[PS_W-1:0];

        if (clear || fire[i])  pc[i] <= '0;
        else if (elig[i])      pc[i] <= pc_eff[i] + PS_ONE;
        else                   pc[i] <= pc_eff[i];

        // A pulse in flight is never cut short by clear, mask or enable.
        if (fire[i])              pcnt[i] <= stretch_eff;
        else if (pcnt[i] != '0)   pcnt[i] <= pcnt[i] - ST_ONE;

        if (clear)                          raw[i] <= '0;
        else if (rise[i] && raw[i] != '1)   raw[i] <= raw[i] + CNT_ONE;

        if (clear)                          acc[i] <= '0;
        else if (fire[i] && acc[i] != '1)   acc[i] <= acc[i] + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_trig_pid_outstage.sv
// Directed bench for trig_pid_outstage: edge timing, prescale, stretch/dead
// time, mask/enable, bus decode, counter clear, saturation and async reset.
module tb_trig_pid_outstage;

  localparam int NCH = 6;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [NCH-1:0]  trig_in;
  logic [31:0]     data;
  logic [15:0]     addr;
  logic            wr, rd;
  logic [31:0]     rdata;
  logic            ack, unknown;
  logic [NCH-1:0]  trig_out;
  logic            trig_or;

  int total = 0;
  int bad   = 0;

  trig_pid_outstage #(.NCH(NCH), .PS_W(8), .CNT_W(4), .STRETCH_W(4), .BASE_ADDR(16'hA000)) dut (
    .clk_100_i (clk),
    .reset_i   (reset_i),
    .trig_in   (trig_in),
    .data      (data),
    .addr      (addr),
    .wr        (wr),
    .rd        (rd),
    .rdata     (rdata),
    .ack       (ack),
    .unknown   (unknown),
    .trig_out  (trig_out),
    .trig_or   (trig_or)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr = a; data = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] q, output logic k, output logic u);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    q = rdata; k = ack; u = unknown;
  endtask

  // Mapped read: expects ack=1, unknown=0 and the given data.
  task automatic check_rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] q;
    logic k, u;
    bus_read(a, q, k, u);
    check(tag, {30'd0, k, u, q}, {30'd0, 1'b1, 1'b0, exp});
  endtask

  // Drives pattern on one channel for cyc cycles; h_ch/h_or record trig_out[ch]/trig_or.
  task automatic drive(input int ch, input logic [31:0] pattern, input int cyc,
                       output logic [31:0] h_ch, output logic [31:0] h_or);
    h_ch = '0;
    h_or = '0;
    for (int c = 0; c < cyc; c++) begin
      trig_in[ch] = pattern[c];
      @(negedge clk);
      h_ch[c] = trig_out[ch];
      h_or[c] = trig_or;
    end
    trig_in[ch] = 1'b0;
  endtask

  initial begin
    logic [31:0] h_ch, h_or, q;
    logic [9:0]  fired;
    logic        k, u;

    reset_i = 1'b0; trig_in = '0; data = '0; addr = '0; wr = 1'b0; rd = 1'b0;
    #12;
    check("reset_outputs", {29'd0, trig_or, ack, unknown, 26'd0, trig_out}, 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);

    // Defaults: 3-cycle input gives one 1-cycle pulse two edges after first sample.
    drive(0, 32'h7, 8, h_ch, h_or);
    check("default_pulse_ch0", 64'(h_ch), 64'h4);
    check("default_pulse_or", 64'(h_or), 64'h4);
    check_rd("raw0_a", 16'hA020, 32'd1);
    check_rd("acc0_a", 16'hA030, 32'd1);

    // Prescale 4 on ch2: edges 4 and 8 fire.
    bus_write(16'hA012, 32'd4);
    fired = '0;
    for (int e = 0; e < 10; e++) begin
      drive(2, 32'h1, 4, h_ch, h_or);
      fired[e] = |h_ch;
    end
    check("prescale_fires", 64'(fired), 64'h088);
    check_rd("raw2", 16'hA022, 32'd10);
    check_rd("acc2", 16'hA032, 32'd2);

    // Stretch 5: edges inside the pulse are dead time.
    bus_write(16'hA002, 32'd5);
    drive(1, 32'h15, 12, h_ch, h_or);
    check("stretch_dead_time", 64'(h_ch), 64'h7C);
    check_rd("raw1", 16'hA021, 32'd3);
    check_rd("acc1", 16'hA031, 32'd1);
    drive(1, 32'h1, 10, h_ch, h_or);
    check("stretch_fresh", 64'(h_ch), 64'h7C);
    check_rd("acc1_b", 16'hA031, 32'd2);

    // Simultaneous wr+rd: write performed, read ignored, single ack.
    check_rd("mask_default", 16'hA001, 32'h3F);
    addr = 16'hA002; data = 32'd0; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    check("wrrd_ack_rdata", {31'd0, ack, rdata}, {31'd0, 1'b1, 32'h3F});
    @(negedge clk);
    check("wrrd_ack_single", 64'(ack), 64'd0);

    // Stretch 0 behaves as 1.
    drive(1, 32'h1, 6, h_ch, h_or);
    check("stretch_zero", 64'(h_ch), 64'h4);

    // Mask ch0, then global disable.
    bus_write(16'hA001, 32'h3E);
    drive(0, 32'h1, 6, h_ch, h_or);
    check("masked_ch0", {h_or, h_ch}, 64'd0);
    check_rd("raw0_b", 16'hA020, 32'd2);
    check_rd("acc0_b", 16'hA030, 32'd1);
    bus_write(16'hA000, 32'd0);
    drive(3, 32'h1, 6, h_ch, h_or);
    check("disabled_or", 64'(h_or), 64'd0);
    check_rd("raw3", 16'hA023, 32'd1);
    check_rd("acc3", 16'hA033, 32'd0);
    bus_write(16'hA000, 32'd1);
    bus_write(16'hA001, 32'h3F);

    // Unmapped offsets.
    bus_read(16'hA03F, q, k, u);
    check("unmapped_3f", {30'd0, k, u, q}, {30'd0, 1'b1, 1'b1, 32'hDEADBEEF});
    bus_read(16'hA026, q, k, u);
    check("unmapped_raw6", {30'd0, k, u, q}, {30'd0, 1'b1, 1'b1, 32'hDEADBEEF});

    // Counter clear in the same cycle as a firing ch4 edge.
    trig_in[4] = 1'b1;
    @(negedge clk);
    addr = 16'hA000; data = 32'd2; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    check("clear_ack_pre", {31'd0, ack, 26'd0, trig_out}, {31'd0, 1'b1, 32'd0});
    @(negedge clk);
    check("clear_pulse_issues", 64'(trig_out), 64'h10);
    trig_in[4] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      check_rd($sformatf("clr_raw%0d", i), 16'hA020 + 16'(i), 32'd0);
      check_rd($sformatf("clr_acc%0d", i), 16'hA030 + 16'(i), 32'd0);
    end
    check_rd("ctrl_after_clear", 16'hA000, 32'd0);
    bus_write(16'hA000, 32'd1);
    check_rd("ctrl_enabled", 16'hA000, 32'd1);

    // Saturation at 4-bit scaler width.
    for (int e = 0; e < 20; e++) drive(5, 32'h1, 2, h_ch, h_or);
    @(negedge clk);
    check_rd("raw5_sat", 16'hA025, 32'd15);
    check_rd("acc5_sat", 16'hA035, 32'd15);

    // Asynchronous reset in the middle of a 5-cycle pulse.
    bus_write(16'hA002, 32'd5);
    trig_in[5] = 1'b1;
    repeat (3) @(negedge clk);
    check("pulse_before_reset", 64'(trig_out), 64'h20);
    #2 reset_i = 1'b0;
    #1;
    check("async_reset_out", {trig_or, trig_out}, 64'd0);
    trig_in[5] = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check_rd("stretch_reset", 16'hA002, 32'd1);
    check_rd("prescale2_reset", 16'hA012, 32'd1);
    check_rd("mask_reset", 16'hA001, 32'h3F);
    check_rd("raw5_reset", 16'hA025, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
